i2c_master_ctrl: RTL

- Parametrised successor to the team's fixed-timing I2C master.
- Adds:
  - a configurable SCL rate;
  - true open-drain SDA/SCL with input synchronisers;
  - a valid/ready command handshake;
  - a master-driven ACK/NACK on reads;
  - a sticky slave-NACK error flag;
  - optional clock stretching.
- Sits between an AXI-lite register front-end (or a sequencer FSM) and the board I2C pins.
- Issues one bus primitive per accepted command.

---
 rtl/i2c_master_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// Open-drain I2C master: one bus primitive (START/WRITE/READ/STOP/RESTART) per accepted command.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during released-SCL phases.
module i2c_master_ctrl #(
  parameter int unsigned QTR_DIV     = 250,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cmd_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] tx_data_i,
  input  logic       rd_nack_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_done_o,
  output logic       ack_err_o,
  output logic       busy_o,
  inout  wire        sda_io,
  inout  wire        scl_io
);

  localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QTR_DIV - 1);

  localparam logic [2:0] C_START   = 3'd1;
  localparam logic [2:0] C_WRITE   = 3'd2;
  localparam logic [2:0] C_READ    = 3'd3;
  localparam logic [2:0] C_STOP    = 3'd4;
  localparam logic [2:0] C_RESTART = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HOLD, S_WRITE, S_READ, S_STOP, S_RESTART
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [5:0]       ph_q, ph_d;       // quarter index within the current state
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       sh_q, sh_d;
  logic             nack_q, nack_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_done_q, tx_done_d;
  logic             ack_err_q, ack_err_d;
  logic [SYNC_STAGES-1:0] sda_sync_q;

  logic sda_low, scl_low, sda_s, stall;
  logic cnt_last, timed, cell_low, bit_ack, accept, sample;
  logic [5:0] ph_end;
  state_e     st_after;

  assign sda_io = sda_low ? 1'b0 : 1'bz;
  assign scl_io = scl_low ? 1'b0 : 1'bz;
  assign sda_s  = sda_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sda_sync_q <= '1;
    else       sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_io};
  end

`ifdef I2C_CLK_STRETCH_EN
  logic [SYNC_STAGES-1:0] scl_sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) scl_sync_q <= '1;
    else       scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_io};
  end
  // Released SCL that still reads low means a slave is holding it: freeze at count 0.
  assign stall = timed && !scl_low && !scl_sync_q[SYNC_STAGES-1] && (cnt_q == '0);
`else
  assign stall = 1'b0;
`endif

  assign cnt_last = (cnt_q == CNT_LAST) && !stall;
  assign timed    = (state_q != S_IDLE) && (state_q != S_HOLD);
  assign cell_low = (ph_q[1:0] == 2'd0) || (ph_q[1:0] == 2'd3);
  assign bit_ack  = ph_q[5];   // quarters 32..35 form the ACK cell
  assign accept   = cmd_valid_i && cmd_ready_o;
  assign sample   = cnt_last && (ph_q[1:0] == 2'd1) &&
                    ((state_q == S_WRITE) || (state_q == S_READ));

  // Line drive decode; every term comes from registers so reset releases the bus at once.
  always_comb begin
    sda_low = 1'b0;
    scl_low = 1'b0;
    case (state_q)
      S_START:   begin sda_low = 1'b1; scl_low = (ph_q >= 6'd2); end
      S_HOLD:    begin sda_low = 1'b1; scl_low = 1'b1; end
      S_WRITE:   begin scl_low = cell_low; sda_low = !bit_ack && !tx_q[~ph_q[4:2]]; end
      S_READ:    begin scl_low = cell_low; sda_low = bit_ack && !nack_q; end
      S_STOP:    begin scl_low = (ph_q == 6'd0); sda_low = (ph_q <= 6'd2); end
      S_RESTART: scl_low = (ph_q == 6'd0);
      default:   ;
    endcase
  end

  always_comb begin
    ph_end   = 6'd0;
    st_after = S_IDLE;
    case (state_q)
      S_START:   begin ph_end = 6'd3;  st_after = S_HOLD;  end
      S_WRITE:   begin ph_end = 6'd35; st_after = S_HOLD;  end
      S_READ:    begin ph_end = 6'd35; st_after = S_HOLD;  end
      S_STOP:    begin ph_end = 6'd4;  st_after = S_IDLE;  end
      S_RESTART: begin ph_end = 6'd2;  st_after = S_START; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    tx_d       = tx_q;
    sh_d       = sh_q;
    nack_d     = nack_q;
    rx_data_d  = rx_data_q;
    ack_err_d  = ack_err_q;
    tx_done_d  = 1'b0;
    rx_valid_d = 1'b0;

    if (timed) begin
      if (stall || cnt_last) cnt_d = '0;
      else                   cnt_d = cnt_q + CW'(1);
      if (cnt_last) begin
        if (ph_q == ph_end) begin
          ph_d    = '0;
          state_d = st_after;
        end else begin
          ph_d = ph_q + 6'd1;
        end
      end
    end

    if (accept) begin
      cnt_d = '0;
      ph_d  = '0;
      if (state_q == S_IDLE) begin
        if (cmd_i == C_START) begin
          state_d   = S_START;
          ack_err_d = 1'b0;
        end
      end else begin
        case (cmd_i)
          C_WRITE:   begin state_d = S_WRITE; tx_d = tx_data_i; end
          C_READ:    begin state_d = S_READ;  nack_d = rd_nack_i; end
          C_STOP:    state_d = S_STOP;
          C_RESTART: state_d = S_RESTART;
          default:   ;
        endcase
      end
    end

    if (sample) begin
      if (!bit_ack && (state_q == S_READ)) sh_d = {sh_q[6:0], sda_s};
      if (bit_ack && (state_q == S_WRITE) && sda_s) ack_err_d = 1'b1;
    end

    // Strobes register into the final cycle of the ACK Q3, one cycle before HOLD.
    tx_done_d  = (state_d == S_WRITE) && (ph_d == 6'd35) && (cnt_d == CNT_LAST);
    rx_valid_d = (state_d == S_READ)  && (ph_d == 6'd35) && (cnt_d == CNT_LAST);
    if (rx_valid_d) rx_data_d = sh_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ph_q       <= '0;
      tx_q       <= '0;
      sh_q       <= '0;
      nack_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_done_q  <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      nack_q     <= nack_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_done_q  <= tx_done_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy_o      = (state_q != S_IDLE);
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign tx_done_o   = tx_done_q;
  assign ack_err_o   = ack_err_q;

endmodule
